// File: rtl/tpu_sdp_ram.sv
// Simple-dual-port word RAM for TPU local buffers: byte-masked writes, registered
// zero-gated reads, selectable read-during-write, and a hardware clear sequencer.
module tpu_sdp_ram #(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 8,
   parameter int RDW_MODE = 0
) (
   input  logic                  i_SCLK,
   input  logic                  i_RESETB,
   input  logic                  i_RAM_WEB,
   input  logic [DATA_W/8-1:0]   i_RAM_BEB,
   input  logic [ADDR_W-1:0]     i_RAM_WADDR,
   input  logic [DATA_W-1:0]     i_RAM_DATA,
   input  logic                  i_RAM_OEB,
   input  logic [ADDR_W-1:0]     i_RAM_RADDR,
   input  logic                  i_CLR,
   output logic [DATA_W-1:0]     o_RAM_DATA,
   output logic                  o_RAM_VALID,
   output logic                  o_BUSY,
   output logic                  o_ACC_ERR
);

   localparam int              DEPTH    = 1 << ADDR_W;
   localparam int              NB       = DATA_W / 8;
   localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W + 1)'(DEPTH - 1);

   typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W:0]     cnt_q;
   logic [DATA_W-1:0]   mem [DEPTH];
   logic                busy, wr_en, rd_en, rej;
   logic [DATA_W-1:0]   rd_word;

   function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_w,
                                                     input logic [DATA_W-1:0] new_w,
                                                     input logic [NB-1:0]     beb);
      logic [DATA_W-1:0] m;
      m = old_w;
      for (int k = 0; k < NB; k++)
         if (!beb[k]) m[8*k +: 8] = new_w[8*k +: 8];
      return m;
   endfunction

   assign busy   = (state_q == ST_CLEAR);
   assign wr_en  = !busy && !i_RAM_WEB;
   assign rd_en  = !busy && !i_RAM_OEB;
   assign rej    = busy && (!i_RAM_WEB || !i_RAM_OEB);
   assign o_BUSY = busy;

   always_ff @(posedge i_SCLK or negedge i_RESETB) begin
      if (!i_RESETB) state_q <= ST_CLEAR;
      else           state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_CLEAR: if (cnt_q == CNT_LAST) state_d = ST_IDLE;
         ST_IDLE:  if (i_CLR)             state_d = ST_CLEAR;
         default:                         state_d = ST_CLEAR;
      endcase
   end

   // Counter is held at zero in IDLE so every clear pass starts from word 0.
   always_ff @(posedge i_SCLK or negedge i_RESETB) begin
      if (!i_RESETB)  cnt_q <= '0;
      else if (busy)  cnt_q <= cnt_q + 1'b1;
      else            cnt_q <= '0;
   end

   // Array has no reset; only the sequencer zeroes it.
   always_ff @(posedge i_SCLK) begin
      if (busy) begin
         mem[cnt_q[ADDR_W-1:0]] <= '0;
      end else if (wr_en) begin
         for (int k = 0; k < NB; k++)
            if (!i_RAM_BEB[k]) mem[i_RAM_WADDR][8*k +: 8] <= i_RAM_DATA[8*k +: 8];
      end
   end

   always_comb begin
      rd_word = mem[i_RAM_RADDR];
      if (RDW_MODE != 0 && wr_en && i_RAM_WADDR == i_RAM_RADDR)
         rd_word = merge_bytes(mem[i_RAM_RADDR], i_RAM_DATA, i_RAM_BEB);
   end

   always_ff @(posedge i_SCLK or negedge i_RESETB) begin
      if (!i_RESETB) begin
         o_RAM_DATA  <= '0;
         o_RAM_VALID <= 1'b0;
         o_ACC_ERR   <= 1'b0;
      end else begin
         o_RAM_DATA  <= rd_en ? rd_word : '0;
         o_RAM_VALID <= rd_en;
         o_ACC_ERR   <= rej;
      end
   end

endmodule

// File: tb/tb_tpu_sdp_ram.sv
// Bench for tpu_sdp_ram: one instance per read-during-write mode, sharing stimulus,
// checked against a word-array reference model.
module tb_tpu_sdp_ram;
   localparam int DW = 16;
   localparam int AW = 8;
   localparam int DEPTH = 256;

   logic          clk = 1'b0;
   logic          rstn;
   logic          web, oeb, clr;
   logic [1:0]    beb;
   logic [AW-1:0] waddr, raddr;
   logic [DW-1:0] wdata;
   logic [DW-1:0] d0, d1;
   logic          v0, v1, b0, b1, e0, e1;

   int n_checks = 0;
   int n_fail   = 0;
   logic [DW-1:0] mem_m [DEPTH];

   always #5 clk = ~clk;

   tpu_sdp_ram #(.DATA_W(DW), .ADDR_W(AW), .RDW_MODE(0)) dut0 (
      .i_SCLK(clk), .i_RESETB(rstn), .i_RAM_WEB(web), .i_RAM_BEB(beb),
      .i_RAM_WADDR(waddr), .i_RAM_DATA(wdata), .i_RAM_OEB(oeb), .i_RAM_RADDR(raddr),
      .i_CLR(clr), .o_RAM_DATA(d0), .o_RAM_VALID(v0), .o_BUSY(b0), .o_ACC_ERR(e0));

   tpu_sdp_ram #(.DATA_W(DW), .ADDR_W(AW), .RDW_MODE(1)) dut1 (
      .i_SCLK(clk), .i_RESETB(rstn), .i_RAM_WEB(web), .i_RAM_BEB(beb),
      .i_RAM_WADDR(waddr), .i_RAM_DATA(wdata), .i_RAM_OEB(oeb), .i_RAM_RADDR(raddr),
      .i_CLR(clr), .o_RAM_DATA(d1), .o_RAM_VALID(v1), .o_BUSY(b1), .o_ACC_ERR(e1));

   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in;
      web = 1'b1; oeb = 1'b1; beb = 2'b11; clr = 1'b0;
   endtask

   task automatic model_clear;
      for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
   endtask

   function automatic logic [DW-1:0] merge_m(input logic [DW-1:0] old_w,
                                             input logic [DW-1:0] new_w,
                                             input logic [1:0]    be);
      logic [DW-1:0] r;
      r[7:0]  = be[0] ? old_w[7:0]  : new_w[7:0];
      r[15:8] = be[1] ? old_w[15:8] : new_w[15:8];
      return r;
   endfunction

   task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] be);
      web = 1'b0; waddr = a; wdata = d; beb = be;
      cyc;
      mem_m[a] = merge_m(mem_m[a], d, be);
      idle_in;
   endtask

   task automatic do_read(input logic [AW-1:0] a);
      oeb = 1'b0; raddr = a;
      cyc;
      idle_in;
   endtask

   task automatic test_reset;
      int n;
      rstn = 1'b0; idle_in; waddr = '0; raddr = '0; wdata = '0;
      repeat (2) cyc;
      n_checks++; if (d0 !== 16'h0 || v0 !== 1'b0) begin n_fail++; $display("FAIL reset_rd got d=%h v=%b exp d=0000 v=0", d0, v0); end
      n_checks++; if (e0 !== 1'b0 || e1 !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b/%b exp 0/0", e0, e1); end
      n_checks++; if (b0 !== 1'b1 || b1 !== 1'b1) begin n_fail++; $display("FAIL reset_busy got %b/%b exp 1/1", b0, b1); end
      rstn = 1'b1;
      n = 0;
      while (b0 === 1'b1 && n < 400) begin cyc; n++; end
      model_clear;
      n_checks++; if (n != 256) begin n_fail++; $display("FAIL init_busy_len got %0d exp 256", n); end
      n_checks++; if (b1 !== 1'b0) begin n_fail++; $display("FAIL init_busy1 got %b exp 0", b1); end
      do_read(8'h55);
      n_checks++; if (v0 !== 1'b1 || d0 !== 16'h0) begin n_fail++; $display("FAIL init_rd0 got v=%b d=%h exp v=1 d=0000", v0, d0); end
      n_checks++; if (v1 !== 1'b1 || d1 !== 16'h0) begin n_fail++; $display("FAIL init_rd1 got v=%b d=%h exp v=1 d=0000", v1, d1); end
   endtask

   task automatic test_write_read;
      do_write(8'h10, 16'hA5A5, 2'b00);
      do_read(8'h10);
      n_checks++; if (v0 !== 1'b1 || d0 !== 16'hA5A5) begin n_fail++; $display("FAIL wr_rd0 got v=%b d=%h exp v=1 d=a5a5", v0, d0); end
      n_checks++; if (v1 !== 1'b1 || d1 !== 16'hA5A5) begin n_fail++; $display("FAIL wr_rd1 got v=%b d=%h exp v=1 d=a5a5", v1, d1); end
      cyc;
      n_checks++; if (v0 !== 1'b0 || d0 !== 16'h0) begin n_fail++; $display("FAIL rd_gate0 got v=%b d=%h exp v=0 d=0000", v0, d0); end
      n_checks++; if (v1 !== 1'b0 || d1 !== 16'h0) begin n_fail++; $display("FAIL rd_gate1 got v=%b d=%h exp v=0 d=0000", v1, d1); end
   endtask

   task automatic test_byte_mask;
      do_write(8'h20, 16'hFFFF, 2'b00);
      do_write(8'h20, 16'h1234, 2'b10);
      do_read(8'h20);
      n_checks++; if (d0 !== 16'hFF34 || d1 !== 16'hFF34) begin n_fail++; $display("FAIL bmask got %h/%h exp ff34", d0, d1); end
      do_write(8'h20, 16'h0000, 2'b11);
      do_read(8'h20);
      n_checks++; if (d0 !== mem_m[8'h20] || d0 !== 16'hFF34) begin n_fail++; $display("FAIL bmask_noop got %h exp ff34", d0); end
   endtask

   task automatic test_rdw;
      do_write(8'h30, 16'h1111, 2'b00);
      web = 1'b0; waddr = 8'h30; wdata = 16'h2222; beb = 2'b00; oeb = 1'b0; raddr = 8'h30;
      cyc;
      idle_in;
      mem_m[8'h30] = 16'h2222;
      n_checks++; if (d0 !== 16'h1111) begin n_fail++; $display("FAIL rdw_old got %h exp 1111", d0); end
      n_checks++; if (d1 !== 16'h2222) begin n_fail++; $display("FAIL rdw_new got %h exp 2222", d1); end
      do_read(8'h30);
      n_checks++; if (d0 !== 16'h2222 || d1 !== 16'h2222) begin n_fail++; $display("FAIL rdw_after got %h/%h exp 2222", d0, d1); end
   endtask

   task automatic test_busy_reject;
      int k;
      do_write(8'h40, 16'hBEEF, 2'b00);
      clr = 1'b1; oeb = 1'b0; raddr = 8'h40;
      cyc;
      idle_in;
      n_checks++; if (v0 !== 1'b1 || d0 !== 16'hBEEF || d1 !== 16'hBEEF) begin n_fail++; $display("FAIL clr_same_rd got v=%b d=%h/%h exp v=1 beef", v0, d0, d1); end
      n_checks++; if (b0 !== 1'b1 || b1 !== 1'b1) begin n_fail++; $display("FAIL clr_busy got %b/%b exp 1/1", b0, b1); end
      k = 0;
      repeat (2) begin cyc; k++; end
      web = 1'b0; waddr = 8'h41; wdata = 16'h1234; beb = 2'b00; oeb = 1'b0; raddr = 8'h40;
      cyc; k++;
      idle_in;
      n_checks++; if (e0 !== 1'b1 || e1 !== 1'b1) begin n_fail++; $display("FAIL acc_err got %b/%b exp 1/1", e0, e1); end
      n_checks++; if (v0 !== 1'b0 || v1 !== 1'b0) begin n_fail++; $display("FAIL busy_rd_valid got %b/%b exp 0/0", v0, v1); end
      cyc; k++;
      n_checks++; if (e0 !== 1'b0 || e1 !== 1'b0) begin n_fail++; $display("FAIL acc_err_pulse got %b/%b exp 0/0", e0, e1); end
      while (b0 === 1'b1 && k < 400) begin cyc; k++; end
      model_clear;
      n_checks++; if (k != 256) begin n_fail++; $display("FAIL clr_busy_len got %0d exp 256", k); end
      do_read(8'h40);
      n_checks++; if (v0 !== 1'b1 || d0 !== 16'h0 || d1 !== 16'h0) begin n_fail++; $display("FAIL clr_rd40 got v=%b d=%h/%h exp v=1 0000", v0, d0, d1); end
      do_read(8'h41);
      n_checks++; if (v0 !== 1'b1 || d0 !== 16'h0 || d1 !== 16'h0) begin n_fail++; $display("FAIL clr_rd41 got v=%b d=%h/%h exp v=1 0000", v0, d0, d1); end
   endtask

   task automatic test_reset_mid_clear;
      int n;
      do_write(8'h77, 16'h5A5A, 2'b00);
      clr = 1'b1;
      cyc;
      idle_in;
      repeat (99) cyc;
      oeb = 1'b0;
      cyc;
      idle_in;
      n_checks++; if (e0 !== 1'b1) begin n_fail++; $display("FAIL mid_err got %b exp 1", e0); end
      rstn = 1'b0;
      #1;
      n_checks++; if (e0 !== 1'b0 || v0 !== 1'b0 || d0 !== 16'h0 || b0 !== 1'b1) begin n_fail++; $display("FAIL mid_rst_out got e=%b v=%b d=%h b=%b exp 0 0 0000 1", e0, v0, d0, b0); end
      repeat (2) cyc;
      rstn = 1'b1;
      n = 0;
      while (b0 === 1'b1 && n < 400) begin
         clr = (n == 10);
         cyc;
         n++;
      end
      idle_in;
      model_clear;
      n_checks++; if (n != 256) begin n_fail++; $display("FAIL mid_busy_len got %0d exp 256", n); end
      do_read(8'h77);
      n_checks++; if (v0 !== 1'b1 || d0 !== 16'h0 || d1 !== 16'h0) begin n_fail++; $display("FAIL mid_rd77 got v=%b d=%h/%h exp v=1 0000", v0, d0, d1); end
   endtask

   task automatic test_random;
      logic          exp_v;
      logic [DW-1:0] old_w, new_w;
      for (int i = 0; i < 400; i++) begin
         web   = 1'($urandom_range(0, 1));
         oeb   = 1'($urandom_range(0, 1));
         waddr = 8'($urandom_range(0, 7));
         raddr = 8'($urandom_range(0, 7));
         beb   = 2'($urandom);
         wdata = 16'($urandom);
         exp_v = !oeb;
         old_w = mem_m[raddr];
         new_w = (!web && waddr == raddr) ? merge_m(old_w, wdata, beb) : old_w;
         cyc;
         if (!web) mem_m[waddr] = merge_m(mem_m[waddr], wdata, beb);
         n_checks++; if (v0 !== exp_v || v1 !== exp_v) begin n_fail++; $display("FAIL rnd_valid[%0d] got %b/%b exp %b", i, v0, v1, exp_v); end
         n_checks++; if (d0 !== (exp_v ? old_w : 16'h0)) begin n_fail++; $display("FAIL rnd_d0[%0d] got %h exp %h", i, d0, exp_v ? old_w : 16'h0); end
         n_checks++; if (d1 !== (exp_v ? new_w : 16'h0)) begin n_fail++; $display("FAIL rnd_d1[%0d] got %h exp %h", i, d1, exp_v ? new_w : 16'h0); end
      end
      idle_in;
      cyc;
   endtask

   initial begin
      test_reset;
      test_write_read;
      test_byte_mask;
      test_rdw;
      test_random;
      test_busy_reject;
      test_reset_mid_clear;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
